stage_sequencer: RTL

Parametrised control sequencer for the multi-cycle core: owns the stage counter, warm-up delay, stall arbitration, error halt, optional single-step and architectural commit (PC and rd write-back). It replaces the gated `clk_with_stalls` scheme with a synchronous `advance` enable that datapath stages qualify their registers with. It sits at the core top level beside the decode/execute units.

---
 rtl/stage_sequencer_pkg.sv | 32 +++
 rtl/priority_encoder_lsb.sv | 26 ++
 rtl/stage_sequencer.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/stage_sequencer_pkg.sv
// Shared core package for the sequencer and its neighbours.
// Holds the sequencer state type, the one-hot stage index constants and
// the bit positions of the error vector sources.
package stage_sequencer_pkg;

  typedef enum logic [1:0] {
    WARMUP    = 2'd0,
    RUN       = 2'd1,
    STEP_WAIT = 2'd2,
    HALT      = 2'd3
  } seq_state_t;

  // Bit positions in the one-hot stage vector (default 4-stage core).
  localparam int unsigned STAGE_IDX_FETCH     = 0;
  localparam int unsigned STAGE_IDX_DECODE    = 1;
  localparam int unsigned STAGE_IDX_EXECUTE   = 2;
  localparam int unsigned STAGE_IDX_WRITEBACK = 3;

  // Bit positions in the error vector.
  localparam int unsigned ONEHOT_ILLEGAL_OPCODE   = 0;
  localparam int unsigned ONEHOT_ILLEGAL_FUNCT3   = 1;
  localparam int unsigned ONEHOT_ILLEGAL_FUNCT7   = 2;
  localparam int unsigned ONEHOT_MISALIGNED_FETCH = 3;
  localparam int unsigned ONEHOT_MISALIGNED_LOAD  = 4;
  localparam int unsigned ONEHOT_MISALIGNED_STORE = 5;
  localparam int unsigned ONEHOT_FETCH_FAULT      = 6;
  localparam int unsigned ONEHOT_LOAD_FAULT       = 7;
  localparam int unsigned ONEHOT_STORE_FAULT      = 8;
  localparam int unsigned ONEHOT_ECALL            = 9;
  localparam int unsigned ONEHOT_EBREAK           = 10;

endpackage

// File: rtl/priority_encoder_lsb.sv
// Lowest-set-bit priority encoder.
// Ports:
//   i_req   : request vector
//   o_index : index of the lowest set bit of i_req (0 when none set)
//   o_valid : high when any bit of i_req is set
module priority_encoder_lsb #(
  parameter int unsigned WIDTH = 11,
  parameter int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] i_req,
  output logic [IDX_W-1:0] o_index,
  output logic             o_valid
);

  always_comb begin
    o_index = '0;
    o_valid = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (i_req[i] && !o_valid) begin
        o_index = IDX_W'(i);
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stage_sequencer.sv
// Control sequencer for the multi-cycle core: stage ring, warm-up delay,
// stall arbitration, error halt, optional single-step and architectural
// commit (PC and rd write-back). Datapath stages qualify their registers
// with the combinational `advance` enable.
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   stall_req           : any bit high blocks advance
//   error_in            : error flags, acted on only in RUN
//   step_mode, step_req : single-step enable and release pulse
//   next_pc             : PC from the pc mux, taken on commit
//   wb_rd_*             : write-back request, latched on commit
//   advance             : stage enable
//   stage               : one-hot current stage
//   pc                  : architectural PC
//   rd_write_enabled, rd_index, rd_write_value : registered rf write
//   halted, error_code  : sticky halt flag and lowest error index
//   retired             : committed instruction count
module stage_sequencer
  import stage_sequencer_pkg::*;
#(
  parameter int unsigned         NUM_STAGES        = 4,
  parameter int unsigned         COMMIT_STAGE      = NUM_STAGES - 1,
  parameter int unsigned         INITIAL_DELAY     = 0,
  parameter int unsigned         NUM_STALL_SOURCES = 1,
  parameter int unsigned         NUM_ERROR_SOURCES = 11,
  parameter int unsigned         PC_WIDTH          = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC          = '0
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NUM_STALL_SOURCES-1:0]         stall_req,
  input  logic [NUM_ERROR_SOURCES-1:0]         error_in,
  input  logic                                 step_mode,
  input  logic                                 step_req,
  input  logic [PC_WIDTH-1:0]                  next_pc,
  input  logic                                 wb_rd_en,
  input  logic [4:0]                           wb_rd_index,
  input  logic [31:0]                          wb_rd_value,
  output logic                                 advance,
  output logic [NUM_STAGES-1:0]                stage,
  output logic [PC_WIDTH-1:0]                  pc,
  output logic                                 rd_write_enabled,
  output logic [4:0]                           rd_index,
  output logic [31:0]                          rd_write_value,
  output logic                                 halted,
  output logic [$clog2(NUM_ERROR_SOURCES)-1:0] error_code,
  output logic [31:0]                          retired
);

  localparam int unsigned ERR_W = $clog2(NUM_ERROR_SOURCES);
  localparam seq_state_t RESET_STATE = (INITIAL_DELAY > 0) ? WARMUP : RUN;
  localparam logic [31:0] WARM_LAST = 32'(INITIAL_DELAY - 1);
  localparam logic [NUM_STAGES-1:0] STAGE_RESET = NUM_STAGES'(1) << STAGE_IDX_FETCH;

  seq_state_t             r_state;
  seq_state_t             w_state_next;
  logic [31:0]            r_warm_cnt;
  logic [NUM_STAGES-1:0]  r_stage;
  logic [PC_WIDTH-1:0]    r_pc;
  logic                   r_rd_we;
  logic [4:0]             r_rd_index;
  logic [31:0]            r_rd_value;
  logic                   r_halted;
  logic [ERR_W-1:0]       r_error_code;
  logic [31:0]            r_retired;

  logic                   w_advance;
  logic                   w_commit;
  logic                   w_err_any;
  logic [ERR_W-1:0]       w_err_idx;
  logic                   w_halt_entry;

  priority_encoder_lsb #(
    .WIDTH(NUM_ERROR_SOURCES),
    .IDX_W(ERR_W)
  ) u_err_enc (
    .i_req  (error_in),
    .o_index(w_err_idx),
    .o_valid(w_err_any)
  );

  // An error blocks advance in the same cycle, so a simultaneous commit is
  // suppressed without an explicit priority term on the commit registers.
  assign w_advance    = (r_state == RUN) && !(|stall_req) && !w_err_any;
  assign w_commit     = w_advance && r_stage[COMMIT_STAGE];
  assign w_halt_entry = (r_state == RUN) && w_err_any;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      WARMUP:    if (r_warm_cnt == WARM_LAST) w_state_next = RUN;
      RUN: begin
        if (w_err_any)                  w_state_next = HALT;
        else if (w_commit && step_mode) w_state_next = STEP_WAIT;
      end
      STEP_WAIT: if (step_req || !step_mode) w_state_next = RUN;
      HALT:      w_state_next = HALT;
      default:   w_state_next = r_state;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= RESET_STATE;
      r_warm_cnt   <= '0;
      r_stage      <= STAGE_RESET;
      r_pc         <= RESET_PC;
      r_rd_we      <= 1'b0;
      r_rd_index   <= '0;
      r_rd_value   <= '0;
      r_halted     <= 1'b0;
      r_error_code <= '0;
      r_retired    <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == WARMUP && r_warm_cnt != '1) r_warm_cnt <= r_warm_cnt + 32'd1;
      if (w_advance) r_stage <= {r_stage[NUM_STAGES-2:0], r_stage[NUM_STAGES-1]};
      r_rd_we <= w_commit && wb_rd_en;
      if (w_commit) begin
        r_pc       <= next_pc;
        r_rd_index <= wb_rd_index;
        r_rd_value <= wb_rd_value;
        r_retired  <= r_retired + 32'd1;
      end
      if (w_halt_entry) begin
        r_halted     <= 1'b1;
        r_error_code <= w_err_idx;
      end
    end
  end

  assign advance          = w_advance;
  assign stage            = r_stage;
  assign pc               = r_pc;
  assign rd_write_enabled = r_rd_we;
  assign rd_index         = r_rd_index;
  assign rd_write_value   = r_rd_value;
  assign halted           = r_halted;
  assign error_code       = r_error_code;
  assign retired          = r_retired;

endmodule
